// File: rtl/note_synth.sv
// Pitch-code playback: filters the 6-bit code, divides clk down to a square-wave tone,
// and streams the matching ±AMP sample as a 16-bit I2S word.
module note_synth #(
  parameter logic [15:0] AMP = 16'h1FFF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] pitch_in,
  output logic       tone,
  output logic       active,
  output logic       mclk,
  output logic       sclk,
  output logic       lrck,
  output logic       sdin
);

  logic [5:0]  p1, p2, pa;
  logic        accept;
  logic [1:0]  octave;
  logic [5:0]  note_code;
  logic [18:0] base_n, half_n, div;
  logic [8:0]  cnt, cnt_next;
  logic [3:0]  bit_idx;
  logic [15:0] s_word, sample;

  // Accept only a code seen identically on two consecutive cycles, so short glitches vanish.
  assign accept = (p1 == p2) && (p1 != pa);

  always_comb begin
    octave = 2'd0;
    if (pa >= 6'd36)      octave = 2'd3;
    else if (pa >= 6'd24) octave = 2'd2;
    else if (pa >= 6'd12) octave = 2'd1;
    note_code = pa - 6'({4'd0, octave} * 6'd12);
    case (note_code[3:0])
      4'd0:    base_n = 19'd382226;
      4'd1:    base_n = 19'd360775;
      4'd2:    base_n = 19'd340524;
      4'd3:    base_n = 19'd321412;
      4'd4:    base_n = 19'd303373;
      4'd5:    base_n = 19'd286346;
      4'd6:    base_n = 19'd270274;
      4'd7:    base_n = 19'd255105;
      4'd8:    base_n = 19'd240788;
      4'd9:    base_n = 19'd227273;
      4'd10:   base_n = 19'd214517;
      4'd11:   base_n = 19'd202477;
      default: base_n = 19'd382226;
    endcase
    half_n = base_n >> octave;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p1     <= 6'd63;
      p2     <= 6'd63;
      pa     <= 6'd63;
      div    <= 19'd0;
      tone   <= 1'b0;
      active <= 1'b0;
    end else begin
      p1 <= pitch_in;
      p2 <= p1;
      if (accept) begin
        pa     <= p1;
        div    <= 19'd0;
        tone   <= (p1 < 6'd48);
        active <= (p1 < 6'd48);
      end else if (active) begin
        if (div == half_n - 19'd1) begin
          div  <= 19'd0;
          tone <= ~tone;
        end else begin
          div <= div + 19'd1;
        end
      end else begin
        div  <= 19'd0;
        tone <= 1'b0;
      end
    end
  end

  assign sample   = active ? (tone ? AMP : (~AMP + 16'd1)) : 16'h0000;
  assign cnt_next = cnt + 9'd1;
  // Slot k carries S[16-k]; mod 16 this is also S[0] for slot 0, taken before the new latch.
  assign bit_idx  = 4'd0 - cnt_next[8:5];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= 9'd0;
      s_word <= 16'h0000;
      sdin   <= 1'b0;
    end else begin
      cnt <= cnt_next;
      if (cnt == 9'd511) s_word <= sample;
      if (cnt[4:0] == 5'd31) sdin <= s_word[bit_idx];
    end
  end

  assign mclk = cnt[1];
  assign sclk = cnt[4];
  assign lrck = cnt[8];

endmodule

// File: tb/tb_note_synth.sv
// Randomized bench for note_synth against a timestamp-based tone/I2S reference model.
module tb_note_synth;

  localparam logic [15:0] AMP = 16'h1FFF;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] pitch_in;
  logic       tone, active, mclk, sclk, lrck, sdin;

  int checks = 0;
  int errors = 0;

  note_synth #(.AMP(AMP)) dut (
    .clk(clk), .reset_n(reset_n), .pitch_in(pitch_in),
    .tone(tone), .active(active), .mclk(mclk), .sclk(sclk), .lrck(lrck), .sdin(sdin)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int half_period(input int code);
    int base [12];
    base = '{382226, 360775, 340524, 321412, 303373, 286346,
             270274, 255105, 240788, 227273, 214517, 202477};
    return base[code % 12] >> (code / 12);
  endfunction

  function automatic logic [15:0] sample_of(input logic act, input logic tn);
    logic [15:0] neg_amp;
    neg_amp = 16'(32'h10000 - 32'(AMP));
    if (!act) return 16'h0000;
    return tn ? AMP : neg_amp;
  endfunction

  // Reference model: e = rising edges since reset release; tone phase from time since acceptance.
  logic [5:0]  pin_edge;
  int          e, pa_m, h1, h2, acc_e, k;
  logic [15:0] s_cur, s_prev;
  logic        tone_m, active_m, sdin_m;

  always @(posedge clk) pin_edge <= pitch_in;

  always @(negedge clk) begin
    if (!reset_n) begin
      e = 0; pa_m = 63; h1 = 63; h2 = 63; acc_e = 0;
      s_cur = '0; s_prev = '0; tone_m = 1'b0; active_m = 1'b0;
    end else begin
      e++;
      if (e % 512 == 0) begin
        s_prev = s_cur;
        s_cur  = sample_of(active_m, tone_m);
      end
      if (h1 == h2 && h1 != pa_m) begin
        pa_m  = h1;
        acc_e = e;
      end
      h2 = h1;
      h1 = int'(pin_edge);
      active_m = (pa_m < 48);
      tone_m   = active_m && ((((e - acc_e) / half_period(pa_m)) % 2) == 0);
    end
    k = (e % 512) / 32;
    sdin_m = (k == 0) ? s_prev[0] : s_cur[16 - k];
    check("active", 32'(active), 32'(active_m));
    check("tone",   32'(tone),   32'(tone_m));
    check("mclk",   32'(mclk),   32'(((e % 512) >> 1) & 1));
    check("sclk",   32'(sclk),   32'(((e % 512) >> 4) & 1));
    check("lrck",   32'(lrck),   32'(((e % 512) >> 8) & 1));
    check("sdin",   32'(sdin),   32'(sdin_m));
  end

  task automatic hold(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic play(input int code, input int n);
    pitch_in = 6'(code);
    hold(n);
  endtask

  initial begin
    reset_n  = 1'b0;
    pitch_in = 6'd0;
    repeat (10) begin
      @(negedge clk);
      #1 pitch_in = 6'($urandom_range(0, 63));
    end
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    play(63, 2048);

    // A3, one-cycle glitch, then C3
    play(9, 3000);
    play(30, 1);
    play(9, 600);
    play(0, 1000);

    // A4, then top note long enough to cover a full high phase and latch low words
    play(21, 300);
    play(47, 26000);

    for (int i = 0; i < 16; i++) begin
      int code, len;
      code = $urandom_range(0, 63);
      len  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 500);
      play(code, len);
    end

    // Asynchronous reset in the middle of a high phase
    play(12, 800);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rst_tone",   32'(tone),   32'd0);
    check("rst_active", 32'(active), 32'd0);
    check("rst_lrck",   32'(lrck),   32'd0);
    check("rst_sclk",   32'(sclk),   32'd0);
    check("rst_mclk",   32'(mclk),   32'd0);
    check("rst_sdin",   32'(sdin),   32'd0);
    hold(5);
    reset_n = 1'b1;
    hold(1500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
